// File: rtl/matrix_mac_nxn_if.sv
// Load/start/readback port bundle for the NxN matrix multiply-accumulate engine.
interface matrix_mac_nxn_if #(
    parameter int unsigned N    = 2,
    parameter int unsigned DW   = 2,
    parameter int unsigned ACCW = 8
);
    localparam int unsigned AW = $clog2(N * N);

    logic            ld_en;
    logic            ld_sel;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            start;
    logic            accum;
    logic            clear;
    logic [AW-1:0]   rd_addr;
    logic [ACCW-1:0] rd_data;
    logic            busy;
    logic            done;
    logic            ovf;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, accum, clear, rd_addr,
        input  rd_data, busy, done, ovf
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, accum, clear, rd_addr,
        output rd_data, busy, done, ovf
    );
endinterface

// File: rtl/matrix_mac_nxn.sv
// NxN unsigned matrix multiply-accumulate engine: C = A*B or C = C + A*B,
// one element at a time (INIT, N MAC cycles, WB), with optional saturation
// and a sticky overflow flag.
module matrix_mac_nxn #(
    parameter int unsigned N    = 2,
    parameter int unsigned DW   = 2,
    parameter int unsigned ACCW = 8,
    parameter bit          SAT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    matrix_mac_nxn_if.slave  bus
);
    localparam int unsigned NN = N * N;
    localparam int unsigned AW = $clog2(NN);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = 2 * DW;
    // Headroom for C plus N products, so the overflow test at WB is exact.
    localparam int unsigned XW = ACCW + 1 + $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MAC,
        S_WB,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   a_q [NN];
    logic [DW-1:0]   b_q [NN];
    logic [ACCW-1:0] c_q [NN];
    logic [IW-1:0]   i_q, j_q, k_q;
    logic [XW-1:0]   acc_q;
    logic            accum_l_q;
    logic            busy_q, done_q, ovf_q;
    logic [ACCW-1:0] rd_data_q;

    logic [AW-1:0]   a_idx_c, b_idx_c, c_idx_c;
    logic [PW-1:0]   prod_c;
    logic            ld_ok_c, rd_ok_c, wb_ovf_c, last_k_c, last_j_c, last_el_c;
    logic [ACCW-1:0] wb_val_c;

    // Element addressing, product and write-back value for the current i/j/k.
    assign a_idx_c   = AW'(32'(i_q) * N + 32'(k_q));
    assign b_idx_c   = AW'(32'(k_q) * N + 32'(j_q));
    assign c_idx_c   = AW'(32'(i_q) * N + 32'(j_q));
    assign prod_c    = PW'(a_q[a_idx_c]) * PW'(b_q[b_idx_c]);
    assign ld_ok_c   = bus.ld_en && (32'(bus.ld_addr) < NN);
    assign rd_ok_c   = 32'(bus.rd_addr) < NN;
    assign wb_ovf_c  = acc_q >= (XW'(1) << ACCW);
    assign wb_val_c  = (wb_ovf_c && SAT) ? '1 : acc_q[ACCW-1:0];
    assign last_k_c  = k_q == IW'(N - 1);
    assign last_j_c  = j_q == IW'(N - 1);
    assign last_el_c = last_j_c && (i_q == IW'(N - 1));

    // Control FSM, matrix storage, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int idx = 0; idx < NN; idx++) begin
                a_q[idx] <= '0;
                b_q[idx] <= '0;
                c_q[idx] <= '0;
            end
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            accum_l_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_ok_c ? c_q[bus.rd_addr] : '0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ld_ok_c) begin
                        if (bus.ld_sel) b_q[bus.ld_addr] <= bus.ld_data;
                        else            a_q[bus.ld_addr] <= bus.ld_data;
                    end
                    if (bus.clear) begin
                        for (int idx = 0; idx < NN; idx++) c_q[idx] <= '0;
                        ovf_q <= 1'b0;
                    end else if (bus.start) begin
                        accum_l_q <= bus.accum;
                        ovf_q     <= 1'b0;
                        i_q       <= '0;
                        j_q       <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_INIT;
                    end
                end
                S_INIT: begin
                    acc_q   <= accum_l_q ? XW'(c_q[c_idx_c]) : '0;
                    k_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    acc_q <= acc_q + XW'(prod_c);
                    k_q   <= k_q + 1'b1;
                    if (last_k_c) state_q <= S_WB;
                end
                S_WB: begin
                    c_q[c_idx_c] <= wb_val_c;
                    if (wb_ovf_c) ovf_q <= 1'b1;
                    if (last_el_c) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        if (last_j_c) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                        state_q <= S_INIT;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
endmodule
